// File: rtl/brom_fetch_pkg.sv
// rtl/brom_fetch_pkg.sv - shared types and constants for the bROM vector fetcher
// Contents: fetch_state_e state encoding, default output-buffer depth and its count width.
package brom_fetch_pkg;

  localparam int DEF_FIFO_DEPTH = 4;
  localparam int FIFO_CNT_W     = $clog2(DEF_FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/brom_fetch_fifo.sv
// rtl/brom_fetch_fifo.sv - small synchronous FIFO carrying data plus a last flag
// Ports: clk, rst (async active-high); wr_en/wr_data/wr_last write side;
//        rd_en/rd_data/rd_last read side (head shown from storage, no bypass from write);
//        count, full, empty status.
module brom_fetch_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic                do_wr;
  logic                do_rd;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign rd_data = mem[rd_ptr][DATA_WIDTH-1:0];
  assign rd_last = mem[rd_ptr][DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= {wr_last, wr_data};
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/brom_vec_fetcher.sv
// rtl/brom_vec_fetcher.sv - burst read initiator for the vector bROM with buffered stream output
// Ports: clk, rst (async active-high); start/base_addr/num_vec command, busy/done status;
//        arvalid/araddr/rready ROM request, rvalid/rdata ROM return;
//        m_valid/m_data/m_last/m_ready output stream.
module brom_vec_fetcher
  import brom_fetch_pkg::*;
#(
  parameter int ROM_DEPTH  = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = $clog2(ROM_DEPTH),
  parameter int CNT_WIDTH  = $clog2(ROM_DEPTH + 1),
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_vec,
  output logic                  busy,
  output logic                  done,
  output logic                  arvalid,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  rready,
  input  logic                  rvalid,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(ROM_DEPTH - 1);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]  num_q;
  logic [CNT_WIDTH-1:0]  issued_q;
  logic [CNT_WIDTH-1:0]  rcv_q;
  logic                  inflight_q;
  logic                  done_q, done_d;

  logic                  start_ok;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] base_mod;
  logic [FCNT_W:0]       credit_used;
  logic                  fifo_wr;
  logic                  fifo_rd;
  logic                  fifo_rd_last;
  logic [FCNT_W-1:0]     fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  // A start is not taken while done is still showing, so the next burst
  // begins the cycle after the completion pulse.
  assign start_ok = (state_q == IDLE) && !done_q && start;

  // Words in the buffer plus the one word still inside the ROM pipeline must
  // leave room, because rvalid cannot be stalled.
  assign credit_used = {1'b0, fifo_count} + {{FCNT_W{1'b0}}, inflight_q};
  assign issue = (state_q == FETCH) && (issued_q < num_q) &&
                 (credit_used < (FCNT_W + 1)'(FIFO_DEPTH));

  assign base_mod = ({1'b0, base_addr} >= (ADDR_WIDTH + 1)'(ROM_DEPTH))
                  ? base_addr - ADDR_WIDTH'(ROM_DEPTH) : base_addr;

  assign arvalid = issue;
  assign rready  = issue;
  assign araddr  = addr_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

  assign fifo_wr = rvalid && inflight_q;
  assign fifo_rd = m_valid && m_ready;
  assign m_valid = !fifo_empty;
  assign m_last  = m_valid && fifo_rd_last;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          if (num_vec != '0) state_d = FETCH;
          else               done_d  = 1'b1;
        end
      end
      FETCH: begin
        if (issue && (issued_q + CNT_WIDTH'(1) == num_q)) state_d = DRAIN;
      end
      DRAIN: begin
        if (!inflight_q && fifo_empty) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      done_q     <= 1'b0;
      addr_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      rcv_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      inflight_q <= issue;
      if (start_ok && (num_vec != '0)) begin
        addr_q   <= base_mod;
        num_q    <= num_vec;
        issued_q <= '0;
        rcv_q    <= '0;
      end
      if (issue) begin
        issued_q <= issued_q + CNT_WIDTH'(1);
        addr_q   <= (addr_q == ADDR_MAX) ? '0 : addr_q + ADDR_WIDTH'(1);
      end
      if (fifo_wr) begin
        rcv_q <= rcv_q + CNT_WIDTH'(1);
      end
    end
  end

  brom_fetch_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .CNT_W      (FCNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (rdata),
    .wr_last (rcv_q == num_q - CNT_WIDTH'(1)),
    .rd_en   (fifo_rd),
    .rd_data (m_data),
    .rd_last (fifo_rd_last),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_brom_vec_fetcher.sv
// tb/tb_brom_vec_fetcher.sv - self-checking bench for brom_vec_fetcher against a mock ROM
module tb_brom_vec_fetcher;

  localparam int ROM_DEPTH  = 16;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 4;
  localparam int CNT_WIDTH  = 5;
  localparam int FIFO_DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [CNT_WIDTH-1:0]  num_vec;
  logic                  busy;
  logic                  done;
  logic                  arvalid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  rready;
  logic                  rvalid = 1'b0;
  logic [DATA_WIDTH-1:0] rdata = '0;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  m_ready;

  logic [DATA_WIDTH-1:0] rom [ROM_DEPTH];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  brom_vec_fetcher #(
    .ROM_DEPTH  (ROM_DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_vec   (num_vec),
    .busy      (busy),
    .done      (done),
    .arvalid   (arvalid),
    .araddr    (araddr),
    .rready    (rready),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready)
  );

  // Mock single-port ROM: one-cycle latency, never reset, never stalls.
  always @(posedge clk) begin
    rvalid <= arvalid && rready;
    rdata  <= rom[araddr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode: 0 always ready, 1 alternating, 2 random, 3 stalled for the first 10 cycles
  task automatic run_burst(input int base, input int num, input int mode);
    logic [DATA_WIDTH-1:0] exp_data [$];
    int                    exp_addr [$];
    int                    issued    = 0;
    int                    delivered = 0;
    int                    done_cnt  = 0;
    int                    first_mv  = -1;
    int                    cyc       = 0;
    bit                    prev_stall = 0;
    logic [DATA_WIDTH-1:0] prev_data = '0;
    logic                  prev_last = 1'b0;

    for (int i = 0; i < num; i++) begin
      exp_addr.push_back((base + i) % ROM_DEPTH);
      exp_data.push_back(rom[(base + i) % ROM_DEPTH]);
    end

    @(negedge clk);
    start     = 1'b1;
    base_addr = ADDR_WIDTH'(base);
    num_vec   = CNT_WIDTH'(num);
    m_ready   = (mode == 0 || mode == 1);

    while (done_cnt == 0 && cyc < 300) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;

      if (prev_stall) begin
        chk("stall_valid", m_valid, 1'b1);
        chk("stall_data", m_data, prev_data);
        chk("stall_last", m_last, prev_last);
      end

      if (arvalid) begin
        chk("rready", rready, 1'b1);
        if (exp_addr.size() == 0) begin
          chk("extra_arvalid", issued + 1, num);
        end else begin
          chk("araddr", araddr, exp_addr.pop_front());
        end
        issued++;
        chk("credit", (issued - delivered) <= FIFO_DEPTH, 1'b1);
      end

      if (m_valid && first_mv < 0) first_mv = cyc;
      if (m_valid) chk("m_last", m_last, delivered == num - 1);

      if (done) begin
        done_cnt++;
        chk("done_delivered", delivered, num);
        if (num == 0) chk("zero_done_cyc", cyc, 1);
      end
      chk("busy", busy, (num > 0) && (done_cnt == 0));

      if (mode == 3 && cyc == 10) chk("stall_issued", issued, FIFO_DEPTH);

      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 2 == 0);
        2:       m_ready = ($urandom_range(0, 1) == 1);
        default: m_ready = (cyc >= 10);
      endcase

      if (m_valid && m_ready) begin
        if (exp_data.size() == 0) begin
          chk("extra_word", delivered + 1, num);
        end else begin
          chk("m_data", m_data, exp_data.pop_front());
        end
        delivered++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end

    chk("done_seen", done_cnt, 1);
    if (mode == 0 && num > 0) chk("first_mvalid_cyc", first_mv, 3);
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
    chk("busy_after", busy, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < ROM_DEPTH; i++) rom[i] = DATA_WIDTH'(i);
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    num_vec   = '0;
    m_ready   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_araddr", araddr, 0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    run_burst(3, 5, 0);
    run_burst(14, 4, 0);
    run_burst(0, 8, 3);
    run_burst(0, 6, 1);
    run_burst(5, 0, 0);
    run_burst(9, 20, 2);

    // Abort: reset lands just after the first issue, while its word is still in the ROM.
    @(negedge clk);
    start     = 1'b1;
    base_addr = 4'd5;
    num_vec   = 5'd5;
    m_ready   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_arvalid", arvalid, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_arvalid_clr", arvalid, 1'b0);
    chk("abort_m_valid", m_valid, 1'b0);
    chk("abort_m_last", m_last, 1'b0);
    chk("abort_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_no_done", done, 1'b0);
    chk("abort_stray_dropped", m_valid, 1'b0);
    run_burst(0, 2, 0);

    for (int k = 0; k < 6; k++) begin
      run_burst($urandom_range(0, ROM_DEPTH - 1), $urandom_range(1, 20), 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/brom_vec_fetcher.md
Name: brom_vec_fetcher

Overview:
- Read initiator for the single-port synchronous vector bROM (1-cycle read latency, arvalid/araddr in, rvalid/rdata out, rready gating request acceptance).
- On a start command, issues a contiguous burst of NUM reads from BASE and buffers the returned words in a small FIFO.
- Presents the words as a valid/ready stream, with a last flag, to downstream compute (e.g. the image-vector consumer).
- Absorbs downstream backpressure, which the bROM cannot do because rvalid is an unstallable 1-cycle pulse.

Parameters:
- ROM_DEPTH, `CFG_IMG_VEC_NUM, number of ROM words; address space modulus.
- DATA_WIDTH, `CFG_VEC_WIDTH, ROM word / stream data width.
- ADDR_WIDTH, $clog2(ROM_DEPTH), ROM address width.
- CNT_WIDTH, $clog2(ROM_DEPTH+1), width of the burst-length field.
- FIFO_DEPTH, 4, output buffer entries; power of two, >= 2.

Ports:
- clk, in, 1, clock; all logic on rising edge.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, single-cycle burst request; sampled only in IDLE.
- base_addr, in, ADDR_WIDTH, first ROM address; captured on accepted start.
- num_vec, in, CNT_WIDTH, words to fetch; captured on accepted start.
- busy, out, 1, high from accepted start until done.
- done, out, 1, one-cycle pulse at burst completion.
- arvalid, out, 1, ROM read request.
- araddr, out, ADDR_WIDTH, ROM read address.
- rready, out, 1, ROM request-accept qualifier.
- rvalid, in, 1, ROM read data valid (1-cycle pulse).
- rdata, in, DATA_WIDTH, ROM read data.
- m_valid, out, 1, stream data valid.
- m_data, out, DATA_WIDTH, stream data.
- m_last, out, 1, marks the final word of the burst.
- m_ready, in, 1, downstream accept.

Behaviour:
- Reset (async, immediate): state=IDLE. busy, done, arvalid, rready, m_valid and m_last are 0. araddr=0. FIFO is emptied. All counters are 0.
- State machine: IDLE -> FETCH -> DRAIN -> IDLE.
  - IDLE: start=1 and num_vec>0 -> capture base/num, busy=1, go to FETCH.
  - IDLE: start=1 and num_vec==0 -> done pulse next cycle, busy stays 0.
  - start outside IDLE is ignored.
- Issue rule (FETCH):
  - Issue when issued<num and (fifo_count + inflight) < FIFO_DEPTH.
  - inflight is the 1-bit count of requests accepted last cycle.
  - On issue, arvalid=rready=1 in the same cycle, and araddr = (base + issued) mod ROM_DEPTH.
  - Address wraps from ROM_DEPTH-1 to 0; a non-power-of-two ROM_DEPTH is handled by compare-and-subtract.
  - Otherwise arvalid=rready=0.
  - Back-to-back issue gives 1 word/cycle when downstream is always ready.
  - After the last issue, go to DRAIN.
- Capture: rvalid=1 while inflight=1 writes rdata into the FIFO unconditionally; space is guaranteed by the credit rule.
  - rvalid while inflight=0 (stray word after reset) is dropped.
  - Simultaneous FIFO write and read in the same cycle keeps fifo_count unchanged.
- Latency:
  - start accepted at cycle T -> first arvalid at T+1 -> rvalid at T+2 -> m_valid at T+3.
  - The FIFO is registered and not fall-through into m_*.
- Stream:
  - m_data/m_valid hold stable while m_valid && !m_ready.
  - m_last=1 with the word whose delivered index == num-1.
- DRAIN: when inflight=0, fifo empty and the last word has been accepted -> done=1 for one cycle, busy=0, go to IDLE.
  - A new start is accepted the cycle after done.
- num_vec > ROM_DEPTH is legal: addresses keep wrapping.
- rst asserted mid-burst aborts the burst: no done pulse and no partial m_last.

Decomposition:
- Package brom_fetch_pkg:
  - state enum typedef fetch_state_e {IDLE, FETCH, DRAIN};
  - localparam FIFO_CNT_W = $clog2(FIFO_DEPTH+1).
- Sub-module brom_fetch_fifo:
  - Synchronous FIFO with parameters DATA_WIDTH and DEPTH.
  - Carries a 1-bit last flag alongside the data.
  - Outputs: count, full, empty.
  - Registered output with async active-high reset.

Test Plan:
- Mock ROM mem[i]=i, ROM_DEPTH=16. Start base=3, num=5, m_ready=1 -> data 3,4,5,6,7 on consecutive cycles; first m_valid 3 cycles after start; m_last on 7; done once; busy high for exactly the burst.
- base=14, num=4 -> araddr 14,15,0,1; data 14,15,0,1.
- m_ready=0 for 10 cycles during num=8 -> arvalid stops after 4 outstanding words, no word is lost or duplicated, then 8 words are delivered in order when m_ready returns.
- m_ready toggling 1010… with num=6 -> m_data stable while stalled; order 0..5; m_last only on 5.
- num_vec=0 -> no arvalid; done pulse the next cycle.
- Reset asserted the cycle after an issue with num=5 -> outputs clear immediately; the stray rvalid is dropped; a following start base=0, num=2 delivers exactly 0,1.
